pipelined_adder: RTL

Parametrised, pipelined add/subtract unit for the mesh datapath. It splits a WIDTH-bit operation into STAGES equal slices and carries between slices through pipeline registers, which keeps the critical path at one slice. Results leave in order behind a valid/ready handshake with full backpressure. It replaces fixed-width combinational adders where width or clock rate would make a single ripple chain too slow.

---
 rtl/add_pkg.sv | 20 ++
 rtl/adder_slice.sv | 22 ++
 rtl/pipelined_adder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | add_pkg: shared types and slice-width helper for pipelined_adder |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package add_pkg;

  // Carry state that rides with each token; operand and sum slices are
  // width-dependent and are bundled around this inside the top level.
  typedef struct packed {
    logic carry;
    logic msb_cin;
  } stage_flags_t;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | adder_slice: combinational SLICE-bit ripple adder               |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  // Carry into the MSB recovered from the MSB sum bit.
  assign msb_cin = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipelined_adder: sliced add/subtract with valid/ready pipeline  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module pipelined_adder
  import add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    stage_flags_t     flags;
  } stage_t;

  stage_t              entry;
  stage_t              pipe  [STAGES];
  logic [STAGES-1:0]   valid;
  logic [STAGES:0]     ready;

  // Subtraction is A + ~B + !borrow, so B is inverted once at entry.
  always_comb begin
    entry             = '0;
    entry.a           = i_a;
    entry.b           = i_sub ? ~i_b : i_b;
    entry.flags.carry = i_cin ^ i_sub;
  end

  assign ready[STAGES] = i_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    logic             src_valid;
    stage_t           stage_d;
    stage_t           stage_q;
    logic             valid_d;
    logic             valid_q;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_msb_cin;

    if (k == 0) begin : g_head
      assign src       = entry;
      assign src_valid = i_valid;
    end else begin : g_body
      assign src       = pipe[k-1];
      assign src_valid = valid[k-1];
    end

    adder_slice #(.W(SLICE)) u_slice (
      .a       (src.a[k*SLICE +: SLICE]),
      .b       (src.b[k*SLICE +: SLICE]),
      .cin     (src.flags.carry),
      .sum     (slice_sum),
      .cout    (slice_cout),
      .msb_cin (slice_msb_cin)
    );

    // A stage may take a new token if empty or if its occupant moves on.
    assign ready[k] = !valid_q || ready[k+1];

    always_comb begin
      stage_d = stage_q;
      valid_d = valid_q;
      if (ready[k]) begin
        valid_d = src_valid;
        if (src_valid) begin
          stage_d                        = src;
          stage_d.sum[k*SLICE +: SLICE]  = slice_sum;
          stage_d.flags.carry            = slice_cout;
          stage_d.flags.msb_cin          = slice_msb_cin;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
        valid_q <= 1'b0;
      end else begin
        stage_q <= stage_d;
        valid_q <= valid_d;
      end
    end

    assign pipe[k]  = stage_q;
    assign valid[k] = valid_q;
  end

  assign o_ready = ready[0];
  assign o_valid = valid[STAGES-1];
  assign o_sum   = pipe[STAGES-1].sum;
  assign o_cout  = pipe[STAGES-1].flags.carry;
  assign o_ovf   = pipe[STAGES-1].flags.carry ^ pipe[STAGES-1].flags.msb_cin;

  // Operands are fully consumed by the final stage.
  logic unused_tail;
  assign unused_tail = ^{pipe[STAGES-1].a, pipe[STAGES-1].b};

endmodule
`default_nettype wire
